// File: rtl/led_ctrl_pwm.sv
// Memory-mapped LED controller: byte-enabled PATTERN/MODE/BLINK_PERIOD/DUTY registers,
// static / blink / PWM-dimmed output modes, registered LED drive with optional inversion.
module led_ctrl_pwm #(
  parameter int N_LED    = 32,
  parameter int PWM_BITS = 8,
  parameter int PERIOD_W = 26,
  parameter int INVERT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [3:0]       byteen,
  input  logic [31:0]      WD,
  output logic [31:0]      RD,
  output logic [N_LED-1:0] led_light
);

  typedef enum logic [1:0] {
    REG_PATTERN = 2'd0,
    REG_MODE    = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_DUTY    = 2'd3
  } reg_sel_e;

  localparam logic [N_LED-1:0] INV_MASK = (INVERT != 0) ? '1 : '0;

  reg_sel_e            sel;
  logic [31:0]         wmask;
  logic                period_wr;

  logic [N_LED-1:0]    pattern, pattern_n;
  logic [1:0]          mode, mode_n;
  logic [PERIOD_W-1:0] blink_period, period_n;
  logic [PWM_BITS-1:0] duty, duty_n;

  logic [PERIOD_W-1:0] blink_cnt;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic [N_LED-1:0]    on_vec;

  assign sel       = reg_sel_e'(addr);
  assign wmask     = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
  assign period_wr = we && (sel == REG_PERIOD) && (byteen != '0);

  // Byte-merge into the addressed register; bits above each register's width are dropped.
  always_comb begin
    pattern_n = pattern;
    mode_n    = mode;
    period_n  = blink_period;
    duty_n    = duty;
    if (we) begin
      unique case (sel)
        REG_PATTERN: pattern_n = (pattern & ~wmask[N_LED-1:0]) | (WD[N_LED-1:0] & wmask[N_LED-1:0]);
        REG_MODE:    mode_n    = (mode & ~wmask[1:0]) | (WD[1:0] & wmask[1:0]);
        REG_PERIOD:  period_n  = (blink_period & ~wmask[PERIOD_W-1:0]) |
                                 (WD[PERIOD_W-1:0] & wmask[PERIOD_W-1:0]);
        REG_DUTY:    duty_n    = (duty & ~wmask[PWM_BITS-1:0]) | (WD[PWM_BITS-1:0] & wmask[PWM_BITS-1:0]);
        default:     ;
      endcase
    end
  end

  always_comb begin
    RD = '0;
    unique case (sel)
      REG_PATTERN: RD[N_LED-1:0]    = pattern;
      REG_MODE:    RD[1:0]          = mode;
      REG_PERIOD:  RD[PERIOD_W-1:0] = blink_period;
      REG_DUTY:    RD[PWM_BITS-1:0] = duty;
      default:     RD = '0;
    endcase
  end

  assign pwm_on = (pwm_cnt < duty);

  always_comb begin
    on_vec = pattern;
    if (mode[0]) on_vec = on_vec & {N_LED{blink_phase}};
    if (mode[1]) on_vec = on_vec & {N_LED{pwm_on}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern      <= '0;
      mode         <= '0;
      blink_period <= '0;
      duty         <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b1;
      pwm_cnt      <= '0;
      led_light    <= INV_MASK;
    end else begin
      pattern      <= pattern_n;
      mode         <= mode_n;
      blink_period <= period_n;
      duty         <= duty_n;
      pwm_cnt      <= pwm_cnt + PWM_BITS'(1);
      led_light    <= on_vec ^ INV_MASK;
      // A BLINK_PERIOD write restarts the half-period and overrides a same-cycle wrap.
      if (period_wr || (blink_period == '0)) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == blink_period - PERIOD_W'(1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_ctrl_pwm.sv
// Scoreboarded bench for led_ctrl_pwm: three instances (default, 4-bit PWM, 8-channel inverted)
// share one register bus; expectations are queued with stimulus and popped on observation.
module tb_led_ctrl_pwm;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  addr;
  logic [3:0]  byteen;
  logic [31:0] WD;

  logic [31:0] rd_a, rd_p, rd_i;
  logic [31:0] led_a, led_p;
  logic [7:0]  led_i;

  always #5 clk = ~clk;

  led_ctrl_pwm #(.N_LED(32), .PWM_BITS(8), .PERIOD_W(26), .INVERT(0)) dut_a (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .byteen(byteen), .WD(WD),
    .RD(rd_a), .led_light(led_a));

  led_ctrl_pwm #(.N_LED(32), .PWM_BITS(4), .PERIOD_W(26), .INVERT(0)) dut_p (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .byteen(byteen), .WD(WD),
    .RD(rd_p), .led_light(led_p));

  led_ctrl_pwm #(.N_LED(8), .PWM_BITS(8), .PERIOD_W(26), .INVERT(1)) dut_i (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .byteen(byteen), .WD(WD),
    .RD(rd_i), .led_light(led_i));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] exp);
    sb_q.push_back('{tag, exp});
  endtask

  task automatic observe(input logic [31:0] got);
    sb_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    we = 1'b1; addr = a; byteen = be; WD = d;
    tick();
    we = 1'b0; byteen = '0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input string tag, input logic [31:0] exp_a,
                        input logic [31:0] exp_i);
    addr = a;
    #1;
    expect_val({tag, "_a"}, exp_a);
    observe(rd_a);
    expect_val({tag, "_i"}, exp_i);
    observe(rd_i);
  endtask

  function automatic logic blink_on(input int unsigned i);
    return ((i - 1) / 4) % 2 == 0;
  endfunction

  int unsigned cnt_a, cnt_p;

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; byteen = '0; WD = '0;
    repeat (10) tick();
    for (int unsigned a = 0; a < 4; a++) rd_chk(2'(a), "reset_rd", 32'h0, 32'h0);
    expect_val("reset_led_a", 32'h0);  observe(led_a);
    expect_val("reset_led_i", 32'hFF); observe({24'h0, led_i});
    reset = 1'b0;

    // Static full write, then one more edge to reach the pins
    expect_val("static_rd", 32'h0afd2403);
    wr(2'd0, 4'hF, 32'h0afd2403);
    observe(rd_a);
    expect_val("static_led_latency", 32'h0);
    observe(led_a);
    expect_val("static_led_a", 32'h0afd2403);
    expect_val("static_led_i", 32'h000000FC);
    tick();
    observe(led_a);
    observe({24'h0, led_i});
    rd_chk(2'd0, "static_rd2", 32'h0afd2403, 32'h03);

    // Upper two bytes only
    wr(2'd0, 4'b1100, 32'h054AFE7B);
    rd_chk(2'd0, "partial_rd", 32'h054A2403, 32'h03);
    expect_val("partial_led", 32'h054A2403);
    tick();
    observe(led_a);

    wr(2'd0, 4'b0000, 32'hFFFFFFFF);
    rd_chk(2'd0, "noben_rd", 32'h054A2403, 32'h03);
    expect_val("noben_led", 32'h054A2403);
    tick();
    observe(led_a);

    wr(2'd3, 4'hF, 32'hFFFFFFFF);
    rd_chk(2'd3, "duty_trunc", 32'hFF, 32'hFF);
    expect_val("duty_trunc_p", 32'hF);
    observe(rd_p);
    wr(2'd3, 4'hF, 32'h0);
    wr(2'd1, 4'hF, 32'hFFFFFFFC);
    rd_chk(2'd1, "mode_trunc", 32'h0, 32'h0);

    // Blink, period 4
    wr(2'd0, 4'hF, 32'hFFFFFFFF);
    wr(2'd1, 4'h1, 32'h1);
    wr(2'd2, 4'hF, 32'd4);
    for (int unsigned i = 1; i <= 13; i++) begin
      expect_val("blink_a", blink_on(i) ? 32'hFFFFFFFF : 32'h0);
      expect_val("blink_i", blink_on(i) ? 32'h00 : 32'hFF);
      tick();
      observe(led_a);
      observe({24'h0, led_i});
    end
    expect_val("blink_rewrite_edge", 32'h0);
    wr(2'd2, 4'hF, 32'd4);
    observe(led_a);
    for (int unsigned i = 1; i <= 8; i++) begin
      expect_val("blink_rewrite", blink_on(i) ? 32'hFFFFFFFF : 32'h0);
      tick();
      observe(led_a);
    end

    wr(2'd2, 4'hF, 32'd0);
    tick();
    for (int unsigned i = 0; i < 6; i++) begin
      expect_val("blink_period0", 32'hFFFFFFFF);
      tick();
      observe(led_a);
    end

    // PWM dimming on bit 0
    wr(2'd0, 4'hF, 32'h1);
    wr(2'd1, 4'hF, 32'h2);
    wr(2'd3, 4'hF, 32'd5);
    repeat (2) tick();
    expect_val("pwm5_p256", 32'd80);
    expect_val("pwm5_a256", 32'd5);
    cnt_a = 0; cnt_p = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      tick();
      cnt_p += 32'(led_p[0]);
      cnt_a += 32'(led_a[0]);
    end
    observe(cnt_p);
    observe(cnt_a);

    wr(2'd3, 4'hF, 32'd0);
    repeat (2) tick();
    expect_val("pwm0_p", 32'd0);
    cnt_p = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      tick();
      cnt_p += 32'(led_p[0]);
    end
    observe(cnt_p);

    wr(2'd3, 4'hF, 32'd15);
    repeat (2) tick();
    expect_val("pwm15_p", 32'd15);
    cnt_p = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      tick();
      cnt_p += 32'(led_p[0]);
    end
    observe(cnt_p);

    // Reset during blink+PWM
    wr(2'd0, 4'hF, 32'hFFFFFFFF);
    wr(2'd1, 4'hF, 32'h3);
    wr(2'd2, 4'hF, 32'd4);
    wr(2'd3, 4'hF, 32'd15);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    for (int unsigned a = 0; a < 4; a++) rd_chk(2'(a), "midreset_rd", 32'h0, 32'h0);
    expect_val("midreset_led_a", 32'h0);  observe(led_a);
    expect_val("midreset_led_i", 32'hFF); observe({24'h0, led_i});
    reset = 1'b0;

    // Reset beats a same-cycle write
    wr(2'd0, 4'hF, 32'h12345678);
    rd_chk(2'd0, "pre_rstwr", 32'h12345678, 32'h78);
    reset = 1'b1; we = 1'b1; addr = 2'd0; byteen = 4'hF; WD = 32'hFFFFFFFF;
    tick();
    reset = 1'b0; we = 1'b0; byteen = '0;
    rd_chk(2'd0, "reset_vs_write", 32'h0, 32'h0);

    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
